lot_count_arbiter: RTL
======================

Name: lot_count_arbiter

Overview:
Shares one car-occupancy counter between two gate lanes. Each lane's sensor FSM emits single-cycle increment (car in) and decrement (car out) request pulses. The block latches these requests, grants one per cycle with round-robin priority, and applies capacity and empty limits. It returns per-request ack or reject pulses and the occupancy status that drives the entry-gate lights.

Parameters:
CW, 4, occupancy counter width in bits.
CAP, 15, lot capacity. Legal range is 1..2^CW-1; an out-of-range value fails elaboration via a generate-time check.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
req  input  4  single-cycle request pulses; slot 0 = lane0 inc, 1 = lane0 dec, 2 = lane1 inc, 3 = lane1 dec
ack  output 4  one-cycle pulse per slot: request applied to the count
rej  output 4  one-cycle pulse per slot: request refused (inc at CAP, dec at 0)
car_count  output CW  current occupancy, registered
full  output 1  registered, car_count == CAP
empty  output 1  registered, car_count == 0
entry_allow  output 2  per lane, registered, equals ~full (drives gate light)
busy  output 1  any pending flag set
overrun  output 1  sticky; a request arrived while the same slot was still pending and not being granted

Behaviour:
- Reset (async, immediate): car_count=0, empty=1, full=0, entry_allow=2'b11, ack=0, rej=0, pend=0, rr pointer=0, overrun=0, busy=0.
- Pending latch: pend[3:0]. At edge k, if req[s]=1, then pend[s] is set.
- If pend[s] is already set and slot s is not granted at edge k, the new pulse is dropped and overrun is set (sticky until rst).
- If pend[s] is being granted at the same edge as a new req[s], the new request stays pending. There is no overrun in this case.
- Arbiter: one grant per cycle, chosen combinationally from pend. Search order starts at rr and goes rr, rr+1, ... mod 4. The first set slot wins.
- After a grant of slot g, rr = (g+1) mod 4. rr is unchanged when nothing is granted.
- Grant of an inc slot:
  - car_count < CAP: car_count+1 and ack[g]=1.
  - car_count == CAP: count unchanged and rej[g]=1.
- Grant of a dec slot:
  - car_count > 0: car_count-1 and ack[g]=1.
  - car_count == 0: count unchanged and rej[g]=1.
- The granted pend bit clears at the same edge, unless re-set by a new req as described above.
- No wrap-around ever; the count saturates logically via reject.
- Latency: req high in cycle t, latched at edge t. If granted immediately, count, full, empty, entry_allow and ack/rej all update together at edge t+1, so they are visible in cycle t+1.
- Worst-case wait with all 4 slots pending is 4 grants.
- ack and rej are one-hot or zero in every cycle and last exactly one cycle.
- full, empty and entry_allow are registered from the next-count value, so they are always coherent with car_count.
- busy = |pend (registered state, combinational OR).
- Simultaneous inc and dec from different lanes are serialized by rr; the net count is correct after both grants.
- Reset asserted mid-operation clears pending requests without ack or rej. Lanes must re-issue them.

Test Plan:
- Reset: assert rst mid-cycle with pend=4'b1111 and car_count=7 -> all outputs go to reset values immediately; no ack/rej pulses after release.
- Single request: req=4'b0001 for one cycle from count 0 -> next cycle car_count=1, ack=4'b0001, empty=0; idle thereafter.
- Round robin: req=4'b0101 in one cycle, count 3, rr=0 -> slot0 acked (count 4), then slot2 acked (count 5), rr ends at 3.
- Full boundary: count 14, req=4'b0101 -> slot0 ack (count 15, full=1, entry_allow=00), then slot2 rej=4'b0100, count stays 15.
- Empty boundary: from reset, req=4'b1010 -> rej on slot 1 then slot 3, car_count stays 0, empty stays 1.
- Overrun: pend all set with rr pointing away from slot3, pulse req[3] again before it is granted -> overrun=1 (sticky); exactly one ack/rej for slot3.

Source files
------------

// File: rtl/lot_count_arbiter.sv
// ============================================================================
// Module   : lot_count_arbiter
// Purpose  : Round-robin arbitration of two gate lanes' inc/dec requests onto
//            one saturating car-occupancy counter with ack/reject feedback.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lot_count_arbiter #(
  parameter int CW  = 4,
  parameter int CAP = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    req,
  output logic [3:0]    ack,
  output logic [3:0]    rej,
  output logic [CW-1:0] car_count,
  output logic          full,
  output logic          empty,
  output logic [1:0]    entry_allow,
  output logic          busy,
  output logic          overrun
);

  // Capacity must be representable and non-zero.
  generate
    if (CAP < 1 || CAP > (2**CW) - 1) begin : g_cap_check
      $error("lot_count_arbiter: CAP out of range for CW");
    end
  endgenerate

  localparam logic [CW-1:0] CAP_C = CW'(CAP);

  logic [3:0]    pend_q, pend_d;
  logic [1:0]    rr_q, rr_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    ack_q, ack_d;
  logic [3:0]    rej_q, rej_d;
  logic          full_q, empty_q;
  logic [1:0]    entry_allow_q;
  logic          overrun_q, overrun_d;

  logic          gnt_valid;
  logic [1:0]    gnt_idx;
  logic [1:0]    scan_idx;
  logic [3:0]    gnt_oh;

  // Pick the first pending slot starting at rr; scanning backwards lets the
  // highest-priority hit be the last assignment.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = 2'd0;
    scan_idx  = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      scan_idx = rr_q + 2'(i);
      if (pend_q[scan_idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
    gnt_oh = gnt_valid ? (4'b0001 << gnt_idx) : 4'b0000;
  end

  // Next count, ack/reject, pointer and pending update for the granted slot.
  always_comb begin
    count_d   = count_q;
    ack_d     = 4'b0000;
    rej_d     = 4'b0000;
    rr_d      = rr_q;
    // A new pulse on a slot that is granted this edge simply re-arms it.
    pend_d    = (pend_q & ~gnt_oh) | req;
    overrun_d = overrun_q | (|(req & pend_q & ~gnt_oh));
    if (gnt_valid) begin
      rr_d = gnt_idx + 2'd1;
      if (!gnt_idx[0]) begin
        if (count_q != CAP_C) begin
          count_d = count_q + 1'b1;
          ack_d   = gnt_oh;
        end else begin
          rej_d   = gnt_oh;
        end
      end else begin
        if (count_q != '0) begin
          count_d = count_q - 1'b1;
          ack_d   = gnt_oh;
        end else begin
          rej_d   = gnt_oh;
        end
      end
    end
  end

  // State and status registers; status is derived from the next count so it
  // always matches car_count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q        <= 4'b0000;
      rr_q          <= 2'd0;
      count_q       <= '0;
      ack_q         <= 4'b0000;
      rej_q         <= 4'b0000;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      entry_allow_q <= 2'b11;
      overrun_q     <= 1'b0;
    end else begin
      pend_q        <= pend_d;
      rr_q          <= rr_d;
      count_q       <= count_d;
      ack_q         <= ack_d;
      rej_q         <= rej_d;
      full_q        <= (count_d == CAP_C);
      empty_q       <= (count_d == '0);
      entry_allow_q <= {2{count_d != CAP_C}};
      overrun_q     <= overrun_d;
    end
  end

  assign ack         = ack_q;
  assign rej         = rej_q;
  assign car_count   = count_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign entry_allow = entry_allow_q;
  assign busy        = |pend_q;
  assign overrun     = overrun_q;

endmodule

`default_nettype wire
